// File: rtl/mem_arbiter.sv
// mem_arbiter
// -----------------------------------------------------------------------------
// Arbitrates the core's 4-bit data RAM between three requesters:
//   - CPU register datapath (fixed top priority, single-cycle read latency)
//   - LCD/video scanout reader (round-robin with savestate, starvation guard)
//   - savestate/debug port (round-robin with video)
//
// Handshake: vid_req/ss_req are held by the requester until the matching
// ack; the ack is combinational and marks the cycle the RAM slot is used.
// Read data is presented exactly one cycle later together with a one-cycle
// valid pulse. The CPU port has no ack: a request is taken in any cycle where
// cpu_stall is low, and must be re-presented after a stall cycle.
//
// Ports:
//   clk, reset_n                     clock, synchronous active-low reset
//   cpu_read_en/cpu_write_en         CPU access request
//   cpu_addr, cpu_write_data         CPU address / write nibble
//   cpu_read_data                    CPU read nibble (held between reads)
//   cpu_stall                        one-cycle forced CPU stall
//   vid_req/vid_addr/vid_ack         video read request
//   vid_valid/vid_data               video read return
//   ss_req/ss_we/ss_addr/ss_wdata    savestate request
//   ss_ack/ss_valid/ss_rdata         savestate handshake / read return
//   ram_addr/ram_we/ram_wdata        RAM command
//   ram_rdata                        RAM synchronous read data (1-cycle)
//   conflict                         sticky: CPU read+write seen together
// -----------------------------------------------------------------------------
module mem_arbiter #(
    parameter int STARVE_LIMIT = 8,
    parameter int ADDR_W       = 12
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cpu_read_en,
    input  logic              cpu_write_en,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [3:0]        cpu_write_data,
    output logic [3:0]        cpu_read_data,
    output logic              cpu_stall,
    input  logic              vid_req,
    input  logic [ADDR_W-1:0] vid_addr,
    output logic              vid_ack,
    output logic              vid_valid,
    output logic [3:0]        vid_data,
    input  logic              ss_req,
    input  logic              ss_we,
    input  logic [ADDR_W-1:0] ss_addr,
    input  logic [3:0]        ss_wdata,
    output logic              ss_ack,
    output logic              ss_valid,
    output logic [3:0]        ss_rdata,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    output logic [3:0]        ram_wdata,
    input  logic [3:0]        ram_rdata,
    output logic              conflict
);

    localparam int                  STARVE_W   = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    // Owner of the read issued last cycle; selects where ram_rdata goes now.
    typedef enum logic [1:0] {
        TAG_NONE = 2'd0,
        TAG_CPU  = 2'd1,
        TAG_VID  = 2'd2,
        TAG_SS   = 2'd3
    } tag_t;

    tag_t                tag;
    tag_t                tag_next;
    logic                rr;          // 0: video goes first, 1: savestate goes first
    logic                rr_next;
    logic [STARVE_W-1:0] starve;
    logic [STARVE_W-1:0] starve_next;
    logic                stall_next;
    logic                conflict_next;
    logic [ADDR_W-1:0]   addr_q;
    logic [ADDR_W-1:0]   addr_next;
    logic [3:0]          cpu_rd_q;
    logic [3:0]          vid_q;
    logic [3:0]          ss_q;

    logic cpu_req;
    logic cpu_grant;
    logic vid_grant;
    logic ss_grant;

    // -------------------------------------------------------------------------
    // Slot grant. Grants are masked while in reset so nothing leaks onto the
    // RAM or the ack lines during the reset cycle.
    // -------------------------------------------------------------------------
    always_comb begin
        cpu_req   = cpu_read_en | cpu_write_en;
        cpu_grant = reset_n & cpu_req & ~cpu_stall;
        vid_grant = 1'b0;
        ss_grant  = 1'b0;
        if (reset_n && !cpu_grant) begin
            if (cpu_stall && vid_req) begin
                // Stall cycle exists solely to serve the starved video reader.
                vid_grant = 1'b1;
            end else if (vid_req && ss_req) begin
                if (rr) ss_grant  = 1'b1;
                else    vid_grant = 1'b1;
            end else if (vid_req) begin
                vid_grant = 1'b1;
            end else if (ss_req) begin
                ss_grant = 1'b1;
            end
        end
    end

    // -------------------------------------------------------------------------
    // RAM command mux and next-state for tag / address hold.
    // -------------------------------------------------------------------------
    always_comb begin
        ram_we    = 1'b0;
        ram_wdata = 4'h0;
        addr_next = addr_q;
        tag_next  = TAG_NONE;
        if (cpu_grant) begin
            addr_next = cpu_addr;
            // A simultaneous read+write keeps only the write.
            if (cpu_write_en) begin
                ram_we    = 1'b1;
                ram_wdata = cpu_write_data;
            end else begin
                tag_next = TAG_CPU;
            end
        end else if (vid_grant) begin
            addr_next = vid_addr;
            tag_next  = TAG_VID;
        end else if (ss_grant) begin
            addr_next = ss_addr;
            if (ss_we) begin
                ram_we    = 1'b1;
                ram_wdata = ss_wdata;
            end else begin
                tag_next = TAG_SS;
            end
        end
    end

    assign ram_addr = addr_next;
    assign vid_ack  = vid_grant;
    assign ss_ack   = ss_grant;

    // -------------------------------------------------------------------------
    // Round-robin pointer, starvation counter, stall and conflict next-state.
    // -------------------------------------------------------------------------
    always_comb begin
        rr_next = rr;
        if (vid_grant)     rr_next = 1'b1;
        else if (ss_grant) rr_next = 1'b0;

        starve_next = starve;
        if (!vid_req || vid_grant || cpu_stall) begin
            starve_next = '0;
        end else if (starve != STARVE_MAX) begin
            starve_next = starve + 1'b1;
        end

        // Never two stall cycles in a row: the stall cycle grants video,
        // which restarts the count.
        stall_next    = (starve == STARVE_MAX) && cpu_req && !cpu_stall;
        conflict_next = conflict | (cpu_grant & cpu_read_en & cpu_write_en);
    end

    // -------------------------------------------------------------------------
    // Read return routing. Data outputs pass ram_rdata through in the return
    // cycle and hold afterwards; an in-flight read is dropped under reset.
    // -------------------------------------------------------------------------
    assign vid_valid     = reset_n && (tag == TAG_VID);
    assign ss_valid      = reset_n && (tag == TAG_SS);
    assign vid_data      = vid_valid ? ram_rdata : vid_q;
    assign ss_rdata      = ss_valid  ? ram_rdata : ss_q;
    assign cpu_read_data = (reset_n && (tag == TAG_CPU)) ? ram_rdata : cpu_rd_q;

    // -------------------------------------------------------------------------
    // State registers.
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            tag       <= TAG_NONE;
            rr        <= 1'b0;
            starve    <= '0;
            cpu_stall <= 1'b0;
            conflict  <= 1'b0;
            addr_q    <= '0;
            cpu_rd_q  <= 4'h0;
            vid_q     <= 4'h0;
            ss_q      <= 4'h0;
        end else begin
            tag       <= tag_next;
            rr        <= rr_next;
            starve    <= starve_next;
            cpu_stall <= stall_next;
            conflict  <= conflict_next;
            addr_q    <= addr_next;
            cpu_rd_q  <= cpu_read_data;
            vid_q     <= vid_data;
            ss_q      <= ss_rdata;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter
// -----------------------------------------------------------------------------
// Directed bench for mem_arbiter with STARVE_LIMIT=8, ADDR_W=12. A behavioural
// synchronous RAM (one-cycle read latency) sits on the RAM port; on its first
// clock it is preloaded with mem[a] = a[3:0], which the expected values below
// are derived from.
// -----------------------------------------------------------------------------
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cpu_read_en, cpu_write_en;
    logic [11:0] cpu_addr;
    logic [3:0]  cpu_write_data, cpu_read_data;
    logic        cpu_stall;
    logic        vid_req, vid_ack, vid_valid;
    logic [11:0] vid_addr;
    logic [3:0]  vid_data;
    logic        ss_req, ss_we, ss_ack, ss_valid;
    logic [11:0] ss_addr;
    logic [3:0]  ss_wdata, ss_rdata;
    logic [11:0] ram_addr;
    logic        ram_we;
    logic [3:0]  ram_wdata, ram_rdata;
    logic        conflict;

    int n_checks = 0;
    int n_fail   = 0;

    mem_arbiter #(.STARVE_LIMIT(8), .ADDR_W(12)) dut (
        .clk(clk), .reset_n(reset_n),
        .cpu_read_en(cpu_read_en), .cpu_write_en(cpu_write_en),
        .cpu_addr(cpu_addr), .cpu_write_data(cpu_write_data),
        .cpu_read_data(cpu_read_data), .cpu_stall(cpu_stall),
        .vid_req(vid_req), .vid_addr(vid_addr), .vid_ack(vid_ack),
        .vid_valid(vid_valid), .vid_data(vid_data),
        .ss_req(ss_req), .ss_we(ss_we), .ss_addr(ss_addr), .ss_wdata(ss_wdata),
        .ss_ack(ss_ack), .ss_valid(ss_valid), .ss_rdata(ss_rdata),
        .ram_addr(ram_addr), .ram_we(ram_we), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .conflict(conflict)
    );

    // Clock / reset block
    always #5 clk = ~clk;

    // RAM model
    logic [3:0] mem [0:4095];
    logic       mem_ready = 1'b0;
    always @(posedge clk) begin
        if (!mem_ready) begin
            for (int i = 0; i < 4096; i++) mem[i] <= 4'(i);
            mem_ready <= 1'b1;
        end else if (ram_we) begin
            mem[ram_addr] <= ram_wdata;
        end
        ram_rdata <= mem[ram_addr];
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        cpu_read_en = 0; cpu_write_en = 0; cpu_addr = '0; cpu_write_data = '0;
        vid_req = 0; vid_addr = '0;
        ss_req = 0; ss_we = 0; ss_addr = '0; ss_wdata = '0;
    endtask

    task automatic test_reset();
        reset_n = 0;
        idle_inputs();
        tick(); tick(); tick();
        n_checks++; if (ram_addr !== 12'h000) begin n_fail++; $display("FAIL reset_ram_addr: got %h want 000", ram_addr); end
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL reset_ram_we: got %b want 0", ram_we); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %b want 0", cpu_stall); end
        n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL reset_conflict: got %b want 0", conflict); end
        n_checks++; if (cpu_read_data !== 4'h0) begin n_fail++; $display("FAIL reset_cpu_rd: got %h want 0", cpu_read_data); end
        n_checks++; if (dut.tag !== 2'd0) begin n_fail++; $display("FAIL reset_tag: got %0d want 0", dut.tag); end
        n_checks++; if (dut.rr !== 1'b0) begin n_fail++; $display("FAIL reset_rr: got %b want 0", dut.rr); end
        n_checks++; if (dut.starve !== 4'd0) begin n_fail++; $display("FAIL reset_starve: got %0d want 0", dut.starve); end
        reset_n = 1;
        tick();
    endtask

    task automatic test_cpu_rw();
        cpu_write_en = 1; cpu_addr = 12'h123; cpu_write_data = 4'hA;
        #1;
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL cpu_wr_we: got %b want 1", ram_we); end
        n_checks++; if (ram_addr !== 12'h123) begin n_fail++; $display("FAIL cpu_wr_addr: got %h want 123", ram_addr); end
        n_checks++; if (ram_wdata !== 4'hA) begin n_fail++; $display("FAIL cpu_wr_data: got %h want a", ram_wdata); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_wr_stall: got %b want 0", cpu_stall); end
        tick();
        cpu_write_en = 0; cpu_read_en = 1;
        #1;
        n_checks++; if (ram_we !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_we: got %b want 0", ram_we); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL cpu_rd_stall: got %b want 0", cpu_stall); end
        tick();
        cpu_read_en = 0;
        #1;
        n_checks++; if (cpu_read_data !== 4'hA) begin n_fail++; $display("FAIL cpu_rd_data: got %h want a", cpu_read_data); end
        n_checks++; if (ram_addr !== 12'h123) begin n_fail++; $display("FAIL cpu_addr_hold: got %h want 123", ram_addr); end
        tick();
        n_checks++; if (cpu_read_data !== 4'hA) begin n_fail++; $display("FAIL cpu_rd_hold: got %h want a", cpu_read_data); end
    endtask

    task automatic test_round_robin();
        logic exp_vid, exp_prev_vid;
        vid_req = 1; vid_addr = 12'h045;
        ss_req = 1; ss_we = 0; ss_addr = 12'h0FE;
        for (int k = 0; k < 4; k++) begin
            #1;
            exp_vid = (k % 2 == 0);
            n_checks++; if (vid_ack !== exp_vid) begin n_fail++; $display("FAIL rr_vid_ack[%0d]: got %b want %b", k, vid_ack, exp_vid); end
            n_checks++; if (ss_ack !== !exp_vid) begin n_fail++; $display("FAIL rr_ss_ack[%0d]: got %b want %b", k, ss_ack, !exp_vid); end
            if (k > 0) begin
                exp_prev_vid = ((k - 1) % 2 == 0);
                n_checks++; if (vid_valid !== exp_prev_vid) begin n_fail++; $display("FAIL rr_vid_valid[%0d]: got %b want %b", k, vid_valid, exp_prev_vid); end
                n_checks++; if (ss_valid !== !exp_prev_vid) begin n_fail++; $display("FAIL rr_ss_valid[%0d]: got %b want %b", k, ss_valid, !exp_prev_vid); end
                if (exp_prev_vid) begin
                    n_checks++; if (vid_data !== 4'h5) begin n_fail++; $display("FAIL rr_vid_data[%0d]: got %h want 5", k, vid_data); end
                end else begin
                    n_checks++; if (ss_rdata !== 4'hE) begin n_fail++; $display("FAIL rr_ss_data[%0d]: got %h want e", k, ss_rdata); end
                end
            end
            tick();
        end
        vid_req = 0; ss_req = 0;
        #1;
        n_checks++; if (ss_valid !== 1'b1) begin n_fail++; $display("FAIL rr_last_ss_valid: got %b want 1", ss_valid); end
        n_checks++; if (ss_rdata !== 4'hE) begin n_fail++; $display("FAIL rr_last_ss_data: got %h want e", ss_rdata); end
        n_checks++; if (vid_valid !== 1'b0) begin n_fail++; $display("FAIL rr_last_vid_valid: got %b want 0", vid_valid); end
        tick();
    endtask

    task automatic test_ss_write();
        ss_req = 1; ss_we = 1; ss_addr = 12'h333; ss_wdata = 4'hC;
        #1;
        n_checks++; if (ss_ack !== 1'b1) begin n_fail++; $display("FAIL ssw_ack: got %b want 1", ss_ack); end
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL ssw_we: got %b want 1", ram_we); end
        n_checks++; if (ram_wdata !== 4'hC) begin n_fail++; $display("FAIL ssw_wdata: got %h want c", ram_wdata); end
        tick();
        ss_we = 0;
        #1;
        n_checks++; if (ss_valid !== 1'b0) begin n_fail++; $display("FAIL ssw_no_valid: got %b want 0", ss_valid); end
        tick();
        ss_req = 0;
        #1;
        n_checks++; if (ss_valid !== 1'b1) begin n_fail++; $display("FAIL ssr_valid: got %b want 1", ss_valid); end
        n_checks++; if (ss_rdata !== 4'hC) begin n_fail++; $display("FAIL ssr_data: got %h want c", ss_rdata); end
        tick();
        n_checks++; if (ss_valid !== 1'b0) begin n_fail++; $display("FAIL ssr_valid_pulse: got %b want 0", ss_valid); end
        n_checks++; if (ss_rdata !== 4'hC) begin n_fail++; $display("FAIL ssr_data_hold: got %h want c", ss_rdata); end
    endtask

    task automatic test_starvation();
        logic [3:0] exp_starve;
        cpu_read_en = 1; cpu_addr = 12'h001;
        vid_req = 1; vid_addr = 12'h077;
        for (int c = 0; c < 10; c++) begin
            #1;
            exp_starve = (c < 8) ? 4'(c) : 4'd8;
            n_checks++; if (dut.starve !== exp_starve) begin n_fail++; $display("FAIL starve_cnt[%0d]: got %0d want %0d", c, dut.starve, exp_starve); end
            n_checks++; if (cpu_stall !== (c == 9)) begin n_fail++; $display("FAIL starve_stall[%0d]: got %b want %b", c, cpu_stall, (c == 9)); end
            n_checks++; if (vid_ack !== (c == 9)) begin n_fail++; $display("FAIL starve_ack[%0d]: got %b want %b", c, vid_ack, (c == 9)); end
            tick();
        end
        vid_req = 0;
        #1;
        n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL starve_vid_valid: got %b want 1", vid_valid); end
        n_checks++; if (vid_data !== 4'h7) begin n_fail++; $display("FAIL starve_vid_data: got %h want 7", vid_data); end
        n_checks++; if (cpu_stall !== 1'b0) begin n_fail++; $display("FAIL starve_unstall: got %b want 0", cpu_stall); end
        n_checks++; if (dut.starve !== 4'd0) begin n_fail++; $display("FAIL starve_clear: got %0d want 0", dut.starve); end
        n_checks++; if (dut.rr !== 1'b1) begin n_fail++; $display("FAIL starve_rr: got %b want 1", dut.rr); end
        n_checks++; if (cpu_read_data !== 4'h1) begin n_fail++; $display("FAIL starve_cpu_hold: got %h want 1", cpu_read_data); end
        tick();
        cpu_read_en = 0;
        #1;
        n_checks++; if (cpu_read_data !== 4'h1) begin n_fail++; $display("FAIL starve_cpu_rd: got %h want 1", cpu_read_data); end
        tick();
    endtask

    task automatic test_conflict();
        cpu_read_en = 1; cpu_write_en = 1; cpu_addr = 12'h010; cpu_write_data = 4'h5;
        #1;
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL conf_we: got %b want 1", ram_we); end
        n_checks++; if (ram_wdata !== 4'h5) begin n_fail++; $display("FAIL conf_wdata: got %h want 5", ram_wdata); end
        tick();
        cpu_read_en = 0; cpu_write_en = 0;
        #1;
        n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_set: got %b want 1", conflict); end
        n_checks++; if (cpu_read_data !== 4'h1) begin n_fail++; $display("FAIL conf_no_rd: got %h want 1", cpu_read_data); end
        n_checks++; if (dut.tag !== 2'd0) begin n_fail++; $display("FAIL conf_tag: got %0d want 0", dut.tag); end
        tick();
        cpu_read_en = 1;
        tick();
        cpu_read_en = 0;
        #1;
        n_checks++; if (cpu_read_data !== 4'h5) begin n_fail++; $display("FAIL conf_written: got %h want 5", cpu_read_data); end
        n_checks++; if (conflict !== 1'b1) begin n_fail++; $display("FAIL conf_sticky: got %b want 1", conflict); end
        tick();
    endtask

    task automatic test_back_to_back();
        cpu_write_en = 1; cpu_addr = 12'h200; cpu_write_data = 4'h9;
        vid_req = 1; vid_addr = 12'h200;
        #1;
        n_checks++; if (ram_we !== 1'b1) begin n_fail++; $display("FAIL b2b_cpu_we: got %b want 1", ram_we); end
        n_checks++; if (vid_ack !== 1'b0) begin n_fail++; $display("FAIL b2b_vid_wait: got %b want 0", vid_ack); end
        tick();
        cpu_write_en = 0;
        #1;
        n_checks++; if (vid_ack !== 1'b1) begin n_fail++; $display("FAIL b2b_vid_ack: got %b want 1", vid_ack); end
        n_checks++; if (ram_addr !== 12'h200) begin n_fail++; $display("FAIL b2b_addr: got %h want 200", ram_addr); end
        tick();
        vid_req = 0;
        #1;
        n_checks++; if (vid_valid !== 1'b1) begin n_fail++; $display("FAIL b2b_vid_valid: got %b want 1", vid_valid); end
        n_checks++; if (vid_data !== 4'h9) begin n_fail++; $display("FAIL b2b_vid_data: got %h want 9", vid_data); end
        tick();
    endtask

    task automatic test_reset_midflight();
        ss_req = 1; ss_we = 0; ss_addr = 12'h0FF;
        #1;
        n_checks++; if (ss_ack !== 1'b1) begin n_fail++; $display("FAIL rst_ss_ack: got %b want 1", ss_ack); end
        tick();
        ss_req = 0; reset_n = 0;
        #1;
        n_checks++; if (ss_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ss_valid0: got %b want 0", ss_valid); end
        tick();
        n_checks++; if (ss_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ss_valid1: got %b want 0", ss_valid); end
        n_checks++; if (dut.tag !== 2'd0) begin n_fail++; $display("FAIL rst_tag: got %0d want 0", dut.tag); end
        n_checks++; if (ram_addr !== 12'h000) begin n_fail++; $display("FAIL rst_ram_addr: got %h want 000", ram_addr); end
        n_checks++; if (conflict !== 1'b0) begin n_fail++; $display("FAIL rst_conflict: got %b want 0", conflict); end
        n_checks++; if (cpu_read_data !== 4'h0) begin n_fail++; $display("FAIL rst_cpu_rd: got %h want 0", cpu_read_data); end
        n_checks++; if (vid_data !== 4'h0) begin n_fail++; $display("FAIL rst_vid_data: got %h want 0", vid_data); end
        n_checks++; if (ss_rdata !== 4'h0) begin n_fail++; $display("FAIL rst_ss_data: got %h want 0", ss_rdata); end
        reset_n = 1;
        tick();
        n_checks++; if (ss_valid !== 1'b0) begin n_fail++; $display("FAIL rst_ss_valid2: got %b want 0", ss_valid); end
    endtask

    initial begin
        test_reset();
        test_cpu_rw();
        test_round_robin();
        test_ss_write();
        test_starvation();
        test_conflict();
        test_back_to_back();
        test_reset_midflight();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Arbiter for the core's 4-bit data RAM (12-bit address). It sits between the RAM macro and three requesters: the CPU register datapath (`memory_*` port), the LCD/video scanout reader, and the savestate/debug port. The CPU has fixed top priority. Video and savestate share idle slots round-robin. A starvation counter can force a one-cycle CPU stall so scanout never stalls indefinitely.

## Interface
Parameters:
- `STARVE_LIMIT`, default 8: number of consecutive waiting cycles for video after which a CPU stall is forced.
- `ADDR_W`, default 12: RAM address width.

Ports:
- `clk`  in  1  clock; all logic on rising edge.
- `reset_n`  in  1  synchronous, active-low reset.
- `cpu_read_en`  in  1  CPU read request this cycle.
- `cpu_write_en`  in  1  CPU write request this cycle.
- `cpu_addr`  in  ADDR_W  CPU address.
- `cpu_write_data`  in  4  CPU write nibble.
- `cpu_read_data`  out  4  RAM read data, valid the cycle after an accepted CPU read.
- `cpu_stall`  out  1  microcode sequencer holds `current_cycle` while high.
- `vid_req`  in  1  video read request; held until `vid_ack`.
- `vid_addr`  in  ADDR_W  video address.
- `vid_ack`  out  1  request accepted this cycle.
- `vid_valid`  out  1  `vid_data` valid; pulses the cycle after `vid_ack`.
- `vid_data`  out  4  read nibble.
- `ss_req`  in  1  savestate request; held until `ss_ack`.
- `ss_we`  in  1  savestate write (1) or read (0).
- `ss_addr`  in  ADDR_W  savestate address.
- `ss_wdata`  in  4  savestate write nibble.
- `ss_ack`  out  1  accepted this cycle.
- `ss_valid`  out  1  read data valid, the cycle after a read ack.
- `ss_rdata`  out  4  read nibble.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_we`  out  1  RAM write enable.
- `ram_wdata`  out  4  RAM write nibble.
- `ram_rdata`  in  4  RAM synchronous read data; one-cycle latency.
- `conflict`  out  1  sticky error flag: CPU read and write were asserted together.

## Operation
- Slot grant is decided combinationally each cycle, in priority order:
  - CPU, if `cpu_read_en | cpu_write_en` and `cpu_stall` is low.
  - Otherwise, among pending video and savestate requests, the one not served last (round-robin pointer `rr`).
  - Otherwise, no grant.
- On a grant, `ram_addr`, `ram_we` and `ram_wdata` are driven from the winner in the same cycle. With no grant, `ram_we` is 0 and `ram_addr` holds its last value.
- CPU read and write asserted together: the write is performed, the read is dropped, and `conflict` is set. `conflict` clears only on reset.
- Read tag register `tag` ∈ {NONE, CPU, VID, SS} records the owner of a read slot. In the next cycle `ram_rdata` is routed to that owner's data output and the matching `vid_valid`/`ss_valid` pulses.
- `cpu_read_data` passes `ram_rdata` through when `tag`=CPU. Otherwise it holds its last value.
- `rr` toggles only when video or savestate is granted. It then points at the other requester.
- Starvation counter `starve` (width ⌈log2(STARVE_LIMIT+1)⌉):
  - Increments each cycle `vid_req` is high and `vid_ack` is low.
  - Clears on `vid_ack` or when `vid_req` is low.
  - When `starve` = STARVE_LIMIT and the CPU is requesting, `cpu_stall` is registered high for exactly one cycle.
- During the stall cycle:
  - CPU requests are ignored.
  - Video wins regardless of `rr`. `rr` is then set to point at savestate.
  - `starve` clears.
- Savestate has no starvation guard. Round-robin alone bounds its wait when the CPU is idle.

## Timing
- Reset: all outputs 0, `tag`=NONE, `rr`=video-first, `starve`=0, `cpu_stall`=0, `conflict`=0. Read data registers are 0.
- Acknowledge latency: `vid_ack`/`ss_ack` assert the same cycle as the grant. Read data follows at +1 cycle.
- CPU read latency is 1 cycle. It matches the regs fetch→write cycle split.
- A CPU request asserted in a stall cycle must be re-presented by the sequencer in the next cycle. No buffering is done here.
- Back-to-back grants to the same or alternating requesters are allowed every cycle. Throughput is 1 access per cycle.
- A reset asserted mid-operation drops any in-flight read: no valid pulse follows, and `tag` returns to NONE.
- The RAM is write-first-agnostic: a read in the cycle after a write to the same address returns the new value.

## Test plan
- Reset, then CPU writes 0xA to 0x123 and reads 0x123 next cycle → `ram_we`=1 on the first cycle, `cpu_read_data`=0xA one cycle after the read, `cpu_stall`=0 throughout.
- `vid_req` and `ss_req` held, CPU idle → acks alternate VID, SS, VID, SS; each valid pulses one cycle after its ack.
- CPU reads every cycle while `vid_req` is held, `STARVE_LIMIT`=8 → `cpu_stall` high exactly one cycle after 8 waiting cycles, `vid_ack` in that cycle, `starve` back to 0.
- `cpu_read_en`=`cpu_write_en`=1, address 0x010, data 0x5 → write occurs, `conflict`=1 and stays 1, no CPU read data update.
- Savestate read of 0x0FF acked, then `reset_n` low in the next cycle → `ss_valid` stays 0, all outputs 0, `tag`=NONE.
- CPU write to 0x200 and video read of 0x200 in the same cycle → CPU wins; video acked the next cycle and returns the new nibble.
